// File: rtl/soc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : soc_mem_pkg
//  Brief    : Shared constants, decode-target type and byte-merge helper for
//             the SoC memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package soc_mem_pkg;

    // Default memory map (byte addresses)
    localparam logic [63:0] c_ram_base_dflt   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] c_tohost_addr_dflt = 64'h0000_0000_4000_0000;
    localparam logic [63:0] c_mtime_addr_dflt  = 64'h0000_0000_0200_BFF8;

    // Which target a data/instruction address resolves to
    typedef enum logic [1:0] {
        TGT_RAM    = 2'd0,
        TGT_TOHOST = 2'd1,
        TGT_MTIME  = 2'd2,
        TGT_NONE   = 2'd3
    } tgt_e;

    // Replace the bytes of old_v selected by strb with the same bytes of new_v
    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int k = 0; k < 8; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_tdp_bytewise.sv
`default_nettype none
// ============================================================================
//  Module   : bram_tdp_bytewise
//  Brief    : True dual-port 64-bit word RAM. Port A is read-only and returns
//             the pre-write word on a same-address collision; port B has byte
//             write strobes and returns the merged (new) word. One-cycle read
//             latency on both ports; array contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
module bram_tdp_bytewise
    import soc_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    // Port A: read-only
    input  logic                  a_en_i,
    input  logic [DEPTH_LOG2-1:0] a_addr_i,
    output logic [63:0]           a_dout_o,
    // Port B: byte-write, write-first
    input  logic                  b_en_i,
    input  logic [7:0]            b_we_i,
    input  logic [DEPTH_LOG2-1:0] b_addr_i,
    input  logic [63:0]           b_din_i,
    output logic [63:0]           b_dout_o
);

    logic [63:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [63:0] a_dout_q;
    logic [63:0] b_dout_q;

    // Port A read: non-blocking sample sees the word before any port B write
    always_ff @(posedge clk) begin
        if (a_en_i) begin
            a_dout_q <= mem_q[a_addr_i];
        end
    end

    // Port B: commit strobed bytes and return the merged word
    always_ff @(posedge clk) begin
        if (b_en_i) begin
            b_dout_q <= byte_merge(mem_q[b_addr_i], b_din_i, b_we_i);
            for (int k = 0; k < 8; k++) begin
                if (b_we_i[k]) begin
                    mem_q[b_addr_i][8*k +: 8] <= b_din_i[8*k +: 8];
                end
            end
        end
    end

    assign a_dout_o = a_dout_q;
    assign b_dout_o = b_dout_q;

endmodule
`default_nettype wire

// File: rtl/soc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : soc_mem_responder
//  Brief    : Memory-side target for the core's instruction and data ports.
//             Decodes RAM, tohost and mtime; RAM lives in bram_tdp_bytewise.
//  Revision : 1.0  initial release
// ============================================================================
module soc_mem_responder
    import soc_mem_pkg::*;
#(
    parameter logic [63:0] RAM_BASE    = c_ram_base_dflt,
    parameter int          DEPTH_LOG2  = 16,
    parameter logic [63:0] TOHOST_ADDR = c_tohost_addr_dflt,
    parameter logic [63:0] MTIME_ADDR  = c_mtime_addr_dflt
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] inst_addra,
    input  logic        inst_ena,
    output logic [31:0] inst_douta,
    input  logic [63:0] data_addra,
    input  logic [63:0] data_dina,
    input  logic        data_ena,
    input  logic [7:0]  data_wea,
    output logic [63:0] data_douta,
    output logic        tohost_valid,
    output logic [63:0] tohost_data
);

    localparam logic [60:0] c_ram_base_w = RAM_BASE[63:3];
    localparam logic [60:0] c_tohost_w   = TOHOST_ADDR[63:3];
    localparam logic [60:0] c_mtime_w    = MTIME_ADDR[63:3];

    // Resolve a byte address to its target (RAM has priority)
    function automatic tgt_e decode(input logic [63:0] addr);
        logic [60:0] w;
        logic [60:0] off;
        w   = addr[63:3];
        off = w - c_ram_base_w;
        if ((w >= c_ram_base_w) && ((off >> DEPTH_LOG2) == '0)) begin
            return TGT_RAM;
        end else if (w == c_tohost_w) begin
            return TGT_TOHOST;
        end else if (w == c_mtime_w) begin
            return TGT_MTIME;
        end
        return TGT_NONE;
    endfunction

    tgt_e                  w_inst_tgt;
    tgt_e                  w_data_tgt;
    logic [60:0]           w_inst_off;
    logic [60:0]           w_data_off;
    logic                  w_ram_a_en;
    logic                  w_ram_b_en;
    logic                  w_wr;
    logic [63:0]           w_ram_a_dout;
    logic [63:0]           w_ram_b_dout;
    logic [63:0]           w_mmio_rd;
    logic                  w_unused;

    logic                  inst_hit_q;
    logic                  inst_hi_q;
    logic                  data_ram_q;
    logic [63:0]           mmio_rd_q;
    logic [63:0]           tohost_q, tohost_d;
    logic                  tohost_valid_q, tohost_valid_d;
    logic [63:0]           mtime_q, mtime_d;

    assign w_inst_tgt = decode(inst_addra);
    assign w_data_tgt = decode(data_addra);
    assign w_inst_off = inst_addra[63:3] - c_ram_base_w;
    assign w_data_off = data_addra[63:3] - c_ram_base_w;
    assign w_ram_a_en = inst_ena && !rst && (w_inst_tgt == TGT_RAM);
    assign w_ram_b_en = data_ena && !rst && (w_data_tgt == TGT_RAM);
    assign w_wr       = data_ena && (data_wea != 8'h00);
    assign w_unused   = ^{inst_addra[1:0], data_addra[2:0],
                          w_inst_off[60:DEPTH_LOG2], w_data_off[60:DEPTH_LOG2]};

    bram_tdp_bytewise #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk      (clk),
        .a_en_i   (w_ram_a_en),
        .a_addr_i (w_inst_off[DEPTH_LOG2-1:0]),
        .a_dout_o (w_ram_a_dout),
        .b_en_i   (w_ram_b_en),
        .b_we_i   (data_wea),
        .b_addr_i (w_data_off[DEPTH_LOG2-1:0]),
        .b_din_i  (data_dina),
        .b_dout_o (w_ram_b_dout)
    );

    // Next-state of the MMIO registers and the value a data access returns
    always_comb begin
        tohost_d       = tohost_q;
        tohost_valid_d = tohost_valid_q;
        mtime_d        = mtime_q + 64'd1;
        if (w_wr && (w_data_tgt == TGT_TOHOST)) begin
            tohost_d = byte_merge(tohost_q, data_dina, data_wea);
            if (tohost_d != 64'd0) begin
                tohost_valid_d = 1'b1;
            end
        end
        if (w_wr && (w_data_tgt == TGT_MTIME)) begin
            mtime_d = byte_merge(mtime_q, data_dina, data_wea);
        end
        // Write-first: a write returns the merged value, a read the current one
        case (w_data_tgt)
            TGT_TOHOST: w_mmio_rd = w_wr ? tohost_d : tohost_q;
            TGT_MTIME:  w_mmio_rd = w_wr ? mtime_d  : mtime_q;
            default:    w_mmio_rd = 64'd0;
        endcase
    end

    // MMIO register state
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q       <= 64'd0;
            tohost_valid_q <= 1'b0;
            mtime_q        <= 64'd0;
        end else begin
            tohost_q       <= tohost_d;
            tohost_valid_q <= tohost_valid_d;
            mtime_q        <= mtime_d;
        end
    end

    // Response steering registers; they only move when their port is used so
    // outputs hold between requests
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_hit_q <= 1'b0;
            inst_hi_q  <= 1'b0;
            data_ram_q <= 1'b0;
            mmio_rd_q  <= 64'd0;
        end else begin
            if (inst_ena) begin
                inst_hit_q <= (w_inst_tgt == TGT_RAM);
                inst_hi_q  <= inst_addra[2];
            end
            if (data_ena) begin
                data_ram_q <= (w_data_tgt == TGT_RAM);
                mmio_rd_q  <= w_mmio_rd;
            end
        end
    end

    assign inst_douta   = !inst_hit_q ? 32'd0 :
                          (inst_hi_q ? w_ram_a_dout[63:32] : w_ram_a_dout[31:0]);
    assign data_douta   = data_ram_q ? w_ram_b_dout : mmio_rd_q;
    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_mem_responder
//  Brief    : Self-checking bench for soc_mem_responder with a small RAM and a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_soc_mem_responder;

    localparam int          DL2 = 6;
    localparam int          NW  = 1 << DL2;
    localparam logic [63:0] RB  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] TH  = 64'h0000_0000_4000_0000;
    localparam logic [63:0] MT  = 64'h0000_0000_0200_BFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] inst_addra;
    logic        inst_ena;
    logic [31:0] inst_douta;
    logic [63:0] data_addra;
    logic [63:0] data_dina;
    logic        data_ena;
    logic [7:0]  data_wea;
    logic [63:0] data_douta;
    logic        tohost_valid;
    logic [63:0] tohost_data;

    always #5 clk = ~clk;

    soc_mem_responder #(
        .RAM_BASE    (RB),
        .DEPTH_LOG2  (DL2),
        .TOHOST_ADDR (TH),
        .MTIME_ADDR  (MT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addra   (inst_addra),
        .inst_ena     (inst_ena),
        .inst_douta   (inst_douta),
        .data_addra   (data_addra),
        .data_dina    (data_dina),
        .data_ena     (data_ena),
        .data_wea     (data_wea),
        .data_douta   (data_douta),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [63:0] mem_m [NW];
    logic [63:0] tohost_m;
    logic        valid_m;
    logic [63:0] mtime_m;
    logic [31:0] inst_m;
    logic [63:0] data_m;

    function automatic logic ram_hit(input logic [63:0] addr);
        logic [63:0] a;
        a = addr & ~64'h7;
        return (a >= RB) && (a < RB + (64'(NW) << 3));
    endfunction

    function automatic int widx(input logic [63:0] addr);
        return int'((addr - RB) >> 3);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] s);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs presented, then
    // compare every output a little after the edge
    task automatic cycle();
        logic [63:0] w;
        logic [63:0] nw;
        logic [63:0] mt_next;
        int          i;
        if (rst) begin
            inst_m   = '0;
            data_m   = '0;
            tohost_m = '0;
            valid_m  = 1'b0;
            mtime_m  = '0;
        end else begin
            mt_next = mtime_m + 64'd1;
            if (inst_ena) begin
                if (ram_hit(inst_addra)) begin
                    w      = mem_m[widx(inst_addra)];
                    inst_m = inst_addra[2] ? w[63:32] : w[31:0];
                end else begin
                    inst_m = '0;
                end
            end
            if (data_ena) begin
                if (ram_hit(data_addra)) begin
                    i        = widx(data_addra);
                    nw       = merge(mem_m[i], data_dina, data_wea);
                    mem_m[i] = nw;
                    data_m   = nw;
                end else if ((data_addra & ~64'h7) == TH) begin
                    nw       = merge(tohost_m, data_dina, data_wea);
                    tohost_m = nw;
                    if (data_wea != 8'h00 && nw != 64'd0) valid_m = 1'b1;
                    data_m   = nw;
                end else if ((data_addra & ~64'h7) == MT) begin
                    nw     = merge(mtime_m, data_dina, data_wea);
                    data_m = nw;
                    if (data_wea != 8'h00) mt_next = nw;
                end else begin
                    data_m = '0;
                end
            end
            mtime_m = mt_next;
        end
        @(posedge clk);
        #1;
        chk("inst_douta",   {32'd0, inst_douta}, {32'd0, inst_m});
        chk("data_douta",   data_douta,   data_m);
        chk("tohost_valid", {63'd0, tohost_valid}, {63'd0, valid_m});
        chk("tohost_data",  tohost_data,  tohost_m);
    endtask

    task automatic drive(input logic ie, input logic [63:0] ia, input logic de,
                         input logic [63:0] da, input logic [63:0] dd, input logic [7:0] dw);
        inst_ena   = ie;
        inst_addra = ia;
        data_ena   = de;
        data_addra = da;
        data_dina  = dd;
        data_wea   = dw;
        cycle();
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 1'b0, 64'd0, 64'd0, 8'h00);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] rnd_addr(input logic inst_port);
        int k;
        k = $urandom_range(0, 11);
        if (k <= 6) return RB + 64'(8 * $urandom_range(0, NW - 1)) + 64'($urandom_range(0, 7));
        if (k == 7) return inst_port ? RB : TH + 64'($urandom_range(0, 7));
        if (k == 8) return MT + 64'($urandom_range(0, 7));
        if (k == 9) return RB + (64'(NW) << 3) + 64'($urandom_range(0, 7));
        if (k == 10) return RB - 64'd8 + 64'($urandom_range(0, 7));
        return 64'h0000_0000_1000_0000 + 64'($urandom_range(0, 255));
    endfunction

    task automatic sweep();
        for (int j = 0; j < NW; j++) begin
            drive(1'b1, RB + 64'(8 * j) + 64'(4 * (j % 2)), 1'b1, RB + 64'(8 * j), 64'd0, 8'h00);
        end
    endtask

    logic [63:0] v10;
    logic [63:0] v15;

    initial begin
        rst = 1'b1;
        // Accesses during reset are discarded
        drive(1'b1, RB, 1'b1, RB + 64'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        drive(1'b0, RB, 1'b1, TH, 64'h5, 8'hFF);
        drive(1'b0, RB, 1'b1, MT, 64'h77, 8'hFF);
        chk("rst_data", data_douta, 64'd0);
        chk("rst_inst", {32'd0, inst_douta}, 64'd0);
        rst = 1'b0;

        // Give every RAM word a known value
        for (int j = 0; j < NW; j++) begin
            drive(1'b0, 64'd0, 1'b1, RB + 64'(8 * j), rnd64(), 8'hFF);
        end

        // Full-word write, then fetch both halves
        drive(1'b0, 64'd0, 1'b1, RB + 64'h10, 64'h1122_3344_5566_7788, 8'hFF);
        drive(1'b1, RB + 64'h10, 1'b0, 64'd0, 64'd0, 8'h00);
        chk("fetch_lo", {32'd0, inst_douta}, 64'h5566_7788);
        drive(1'b1, RB + 64'h14, 1'b0, 64'd0, 64'd0, 8'h00);
        chk("fetch_hi", {32'd0, inst_douta}, 64'h1122_3344);
        idle();
        chk("fetch_hold", {32'd0, inst_douta}, 64'h1122_3344);

        // Partial-strobe write returns the merged word
        drive(1'b0, 64'd0, 1'b1, RB + 64'h10, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
        drive(1'b0, 64'd0, 1'b1, RB + 64'h10, 64'h0, 8'h0F);
        chk("partial_wr", data_douta, 64'hAAAA_BBBB_0000_0000);

        // Collision: fetch sees the old word, write commits
        drive(1'b0, 64'd0, 1'b1, RB + 64'h10, 64'h0123_4567_89AB_CDEF, 8'hFF);
        drive(1'b1, RB + 64'h10, 1'b1, RB + 64'h10, 64'h0, 8'hFF);
        chk("collide_inst", {32'd0, inst_douta}, 64'h89AB_CDEF);
        drive(1'b0, 64'd0, 1'b1, RB + 64'h10, 64'h0, 8'h00);
        chk("collide_rd", data_douta, 64'd0);

        // tohost: sticky valid, cleared only by reset
        drive(1'b0, 64'd0, 1'b1, TH, 64'h1, 8'hFF);
        chk("tohost_set_v", {63'd0, tohost_valid}, 64'd1);
        chk("tohost_set_d", tohost_data, 64'd1);
        drive(1'b0, 64'd0, 1'b1, TH, 64'h0, 8'hFF);
        chk("tohost_zero_v", {63'd0, tohost_valid}, 64'd1);
        chk("tohost_zero_d", tohost_data, 64'd0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("tohost_rst_v", {63'd0, tohost_valid}, 64'd0);

        // mtime: reads in cycles 10 and 15 after release differ by 5
        for (int j = 1; j <= 9; j++) idle();
        drive(1'b0, 64'd0, 1'b1, MT, 64'd0, 8'h00);
        v10 = data_douta;
        for (int j = 11; j <= 14; j++) idle();
        drive(1'b0, 64'd0, 1'b1, MT, 64'd0, 8'h00);
        v15 = data_douta;
        chk("mtime_delta", v15 - v10, 64'd5);
        drive(1'b0, 64'd0, 1'b1, MT, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        idle();
        drive(1'b0, 64'd0, 1'b1, MT, 64'd0, 8'h00);
        chk("mtime_wrap", data_douta, 64'd0);

        // Unmapped accesses return 0 and never touch RAM
        drive(1'b1, TH, 1'b1, 64'h0000_0000_1000_0000, 64'd0, 8'h00);
        chk("unmap_rd", data_douta, 64'd0);
        chk("unmap_fetch", {32'd0, inst_douta}, 64'd0);
        drive(1'b0, 64'd0, 1'b1, 64'h0000_0000_1000_0000, rnd64(), 8'hFF);
        sweep();

        // Randomised traffic on both ports, with occasional resets
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, rnd_addr(1'b1),
                  $urandom_range(0, 3) != 0, rnd_addr(1'b0), rnd64(),
                  ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom()));
        end
        rst = 1'b0;
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
